// File: rtl/imem_prefetch_queue.sv
// -----------------------------------------------------------------------------
// imem_prefetch_queue
//   Instruction-fetch front end sitting directly upstream of the core's IF stage.
//   Issues sequential word reads to a synchronous instruction memory with a fixed
//   one-cycle read latency. Returned {pc, instr} pairs are buffered in a
//   DEPTH-entry FIFO and handed to the core over a valid/ready handshake.
//   A redirect flushes everything in flight and restarts fetch at redirect_pc.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   redirect     flush queue and restart fetch at redirect_pc
//   redirect_pc  new fetch address, low two bits ignored
//   imem_req     read request to instruction memory this cycle
//   imem_addr    word-aligned read address (meaningful when imem_req)
//   imem_rdata   read data, valid the cycle after imem_req
//   instr_valid  head entry valid
//   instr_ready  core accepts the head entry
//   instrF       head instruction, NOP when empty
//   pcF          head PC, zero when empty
//   count        current FIFO occupancy
// -----------------------------------------------------------------------------
module imem_prefetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       redirect,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       imem_req,
   output logic [XLEN-1:0]            imem_addr,
   input  logic [XLEN-1:0]            imem_rdata,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [XLEN-1:0]            instrF,
   output logic [XLEN-1:0]            pcF,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int              PW        = $clog2(DEPTH);
   localparam int              CW        = PW + 1;
   localparam logic [XLEN-1:0] INSTR_NOP = XLEN'(32'h0000_0013);

   logic [XLEN-1:0] fetchPc;
   logic [XLEN-1:0] inflightPc;
   logic            inflightQ;
   logic [PW-1:0]   wrPtr;
   logic [PW-1:0]   rdPtr;
   logic [CW-1:0]   cntQ;

   logic [XLEN-1:0] pcMem    [DEPTH];
   logic [XLEN-1:0] instrMem [DEPTH];

   logic            issue;
   logic            push;
   logic            pop;
   logic            notEmpty;
   logic [CW:0]     credit;

   // Occupancy plus the outstanding read; one extra bit since it can reach DEPTH+1
   // in principle. A pop in the same cycle is deliberately not credited back.
   assign credit   = {1'b0, cntQ} + (CW+1)'(inflightQ);
   assign notEmpty = (cntQ != '0);

   assign issue    = rst_n & ~redirect & (credit < (CW+1)'(DEPTH));
   assign push     = rst_n & ~redirect & inflightQ;
   assign pop      = instr_valid & instr_ready & ~redirect;

   assign imem_req    = issue;
   assign imem_addr   = fetchPc;
   assign instr_valid = rst_n & notEmpty;
   assign instrF      = instr_valid ? instrMem[rdPtr] : INSTR_NOP;
   assign pcF         = instr_valid ? pcMem[rdPtr]    : '0;
   assign count       = cntQ;

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetchPc    <= RESET_PC;
         inflightQ  <= 1'b0;
         inflightPc <= '0;
         wrPtr      <= '0;
         rdPtr      <= '0;
         cntQ       <= '0;
      end else if (redirect) begin
         // Redirect wins over issue, push and pop; the response landing this
         // cycle belongs to the old path and is simply dropped.
         fetchPc   <= redirect_pc & ~XLEN'(3);
         inflightQ <= 1'b0;
         wrPtr     <= '0;
         rdPtr     <= '0;
         cntQ      <= '0;
      end else begin
         inflightQ <= issue;
         if (issue) begin
            inflightPc <= fetchPc;
            fetchPc    <= fetchPc + XLEN'(4);
         end
         if (push) wrPtr <= wrPtr + PW'(1);
         if (pop)  rdPtr <= rdPtr + PW'(1);
         case ({push, pop})
            2'b10:   cntQ <= cntQ + CW'(1);
            2'b01:   cntQ <= cntQ - CW'(1);
            default: cntQ <= cntQ;
         endcase
      end
   end

   // NOTE: the FIFO storage has no reset; an entry is only ever read after it
   // has been written, and count/pointers are what reset clears.
   always_ff @(posedge clk) begin
      if (push) begin
         pcMem[wrPtr]    <= inflightPc;
         instrMem[wrPtr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_imem_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_imem_prefetch_queue
//   Directed bench for imem_prefetch_queue. A behavioural one-cycle-latency
//   memory returns an address-derived word. The stimulus process loads the
//   expected PC stream into a scoreboard queue whenever fetch (re)starts; a
//   monitor pops and compares on every accepted handshake. Cycle-specific
//   expectations (count, request, address) are checked inline.
// -----------------------------------------------------------------------------
module tb_imem_prefetch_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            instr_valid;
   logic            instr_ready;
   logic [XLEN-1:0] instrF;
   logic [XLEN-1:0] pcF;
   logic [CW-1:0]   count;

   int passCnt  = 0;
   int checkCnt = 0;
   logic [31:0] expQ[$];

   imem_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instrF      (instrF),
      .pcF         (pcF),
      .count       (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imemWord(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   // Synchronous memory: data for a request shows up the following cycle;
   // garbage otherwise so stale returns would be visible.
   initial imem_rdata = 32'hDEAD_BEEF;
   always @(posedge clk)
      imem_rdata <= imem_req ? imemWord(imem_addr) : 32'hDEAD_BEEF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expectFrom(input logic [31:0] pc, input int n);
      logic [31:0] p;
      expQ.delete();
      p = pc;
      for (int i = 0; i < n; i++) begin
         expQ.push_back(p);
         p = p + 32'd4;
      end
   endtask

   // Scoreboard monitor: every accepted head must be the next expected PC
   // carrying the word the memory holds at that PC.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready && !redirect) begin
         if (expQ.size() == 0) begin
            check("unexpected_pop", pcF, 32'hFFFF_FFFF);
         end else begin
            logic [31:0] e;
            e = expQ.pop_front();
            check("sb_pc", pcF, e);
            check("sb_instr", instrF, imemWord(e));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b1;
      repeat (3) nextCycle();

      // Reset state
      @(negedge clk);
      check("rst_valid", instr_valid, 0);
      check("rst_req",   imem_req,    0);
      check("rst_instr", instrF,      NOP);
      check("rst_pc",    pcF,         0);
      check("rst_count", count,       0);

      // 1: reset release, streaming
      nextCycle(); rst_n = 1'b1; expectFrom(32'h0, 32);
      @(negedge clk);
      check("t1_req_c1",   imem_req,    1);
      check("t1_addr_c1",  imem_addr,   32'h0);
      check("t1_valid_c1", instr_valid, 0);
      nextCycle(); @(negedge clk);
      check("t1_addr_c2",  imem_addr,   32'h4);
      check("t1_valid_c2", instr_valid, 0);
      nextCycle(); @(negedge clk);
      check("t1_valid_c3", instr_valid, 1);
      check("t1_count_c3", count,       1);
      check("t1_addr_c3",  imem_addr,   32'h8);
      repeat (5) nextCycle();

      // 2: stall until full, then drain without gaps
      nextCycle(); rst_n = 1'b0; instr_ready = 1'b0; expectFrom(32'h0, 32);
      nextCycle(); rst_n = 1'b1;
      repeat (9) nextCycle();
      @(negedge clk);
      check("t2_count_full", count,       4);
      check("t2_req_full",   imem_req,    0);
      check("t2_valid_full", instr_valid, 1);
      check("t2_head_pc",    pcF,         32'h0);
      check("t2_head_instr", instrF,      imemWord(32'h0));
      nextCycle(); instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) check("t2_req_conservative", imem_req, 0);
         check("t2_drain_valid", instr_valid, 1);
         nextCycle();
      end

      // 3: redirect with three entries queued
      rst_n = 1'b0; instr_ready = 1'b0; expQ.delete();
      nextCycle(); rst_n = 1'b1;
      repeat (4) nextCycle();
      redirect = 1'b1; redirect_pc = 32'h0000_0102; expectFrom(32'h100, 32);
      @(negedge clk);
      check("t3_count_pre", count,    3);
      check("t3_req_redir", imem_req, 0);
      nextCycle(); redirect = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      check("t3_count_post", count,       0);
      check("t3_valid_post", instr_valid, 0);
      check("t3_req_post",   imem_req,    1);
      check("t3_addr_post",  imem_addr,   32'h100);
      nextCycle(); @(negedge clk);
      check("t3_addr_2", imem_addr, 32'h104);
      check("t3_valid_2", instr_valid, 0);
      nextCycle(); @(negedge clk);
      check("t3_valid_3", instr_valid, 1);
      check("t3_pc_3",    pcF,         32'h100);
      repeat (4) nextCycle();

      // 4: redirect coinciding with a return and a pop
      redirect = 1'b1; redirect_pc = 32'h0000_0200; expectFrom(32'h200, 32);
      @(negedge clk);
      check("t4_count_pre", count,       1);
      check("t4_valid_pre", instr_valid, 1);
      nextCycle(); redirect = 1'b0;
      @(negedge clk);
      check("t4_count_post", count,       0);
      check("t4_valid_post", instr_valid, 0);
      check("t4_addr_post",  imem_addr,   32'h200);
      nextCycle(); @(negedge clk);
      check("t4_addr_2", imem_addr, 32'h204);
      nextCycle(); @(negedge clk);
      check("t4_pc_3", pcF, 32'h200);
      repeat (3) nextCycle();

      // 5: redirect to the top of the address space, fetch wraps to zero
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; expectFrom(32'hFFFF_FFFC, 32);
      nextCycle(); redirect = 1'b0;
      @(negedge clk);
      check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
      nextCycle(); @(negedge clk);
      check("t5_addr_wrap", imem_addr, 32'h0);
      nextCycle(); @(negedge clk);
      check("t5_pc_top", pcF, 32'hFFFF_FFFC);
      repeat (3) nextCycle();

      // 6: reset asserted mid-stream with two entries queued
      instr_ready = 1'b0;
      nextCycle(); rst_n = 1'b0; instr_ready = 1'b1; expectFrom(32'h0, 32);
      @(negedge clk);
      check("t6_count_pre", count,       2);
      check("t6_valid_rst", instr_valid, 0);
      check("t6_req_rst",   imem_req,    0);
      check("t6_pc_rst",    pcF,         0);
      check("t6_instr_rst", instrF,      NOP);
      nextCycle(); rst_n = 1'b1;
      @(negedge clk);
      check("t6_count_post", count,       0);
      check("t6_valid_post", instr_valid, 0);
      check("t6_req_post",   imem_req,    1);
      check("t6_addr_post",  imem_addr,   32'h0);
      nextCycle(); @(negedge clk);
      check("t6_addr_2", imem_addr, 32'h4);
      nextCycle(); @(negedge clk);
      check("t6_pc_3", pcF, 32'h0);
      repeat (4) nextCycle();

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
